mem_access_ctrl: RTL and testbench



---
 rtl/mem_access_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer for a req/ack data-memory port.
// Accepts one access from the EX/MEM register, checks alignment, drives a
// word-aligned request with byte enables and lane-shifted store data, and
// returns aligned, sign/zero-extended load data to writeback.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mem_re_in/we_in   load/store request (both high is handled as a store)
//   mul_stall         upstream stall; blocks acceptance of a new access
//   funct3            RV32 load/store width code
//   addr_in           effective byte address
//   rs2_data_in       store source data
//   dm_req/we/addr    memory request, direction, word address
//   dm_bwe/w_data     byte write enables, lane-aligned store data
//   dm_ack/r_data     memory completion strobe and read data
//   load_data/valid   extended load result and its one-cycle strobe
//   mem_err           one-cycle strobe on misalignment/illegal width/timeout
//   MEM_stall         combinational pipeline freeze
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_re_in,
    input  logic        mem_we_in,
    input  logic        mul_stall,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr_in,
    input  logic [31:0] rs2_data_in,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_bwe,
    output logic [31:0] dm_w_data,
    input  logic        dm_ack,
    input  logic [31:0] dm_r_data,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        mem_err,
    output logic        MEM_stall
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned XLEN  = 32;

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dm_req_q, dm_req_d;
    logic              dm_we_q, dm_we_d;
    logic [XLEN-1:0]   dm_addr_q, dm_addr_d;
    logic [3:0]        dm_bwe_q, dm_bwe_d;
    logic [XLEN-1:0]   dm_w_data_q, dm_w_data_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              mem_err_q, mem_err_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        lane_q, lane_d;

    logic              accept;
    logic              fault;
    logic              illegal;
    logic              misaligned;
    logic [1:0]        lane;
    logic [3:0]        bwe_new;
    logic [XLEN-1:0]   wdata_new;
    logic [XLEN-1:0]   rd_shifted;
    logic [XLEN-1:0]   load_ext;

    assign accept    = (state_q == IDLE) && (mem_re_in || mem_we_in) && !mul_stall;
    assign MEM_stall = accept || (state_q == REQ);

    // Decode the incoming access: lane enables, shifted data, fault detection.
    always_comb begin
        lane      = addr_in[1:0];
        bwe_new   = 4'b0000;
        illegal   = 1'b0;
        wdata_new = rs2_data_in << {lane, 3'b000};
        if (mem_we_in) begin
            case (funct3)
                3'b000:  bwe_new = 4'b0001 << lane;
                3'b001:  bwe_new = 4'b0011 << lane;
                3'b010:  bwe_new = 4'b1111;
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
                default:                                illegal = 1'b1;
            endcase
        end
        // funct3[1:0] carries the access size for both signed and unsigned loads
        misaligned = ((funct3[1:0] == 2'b01) && addr_in[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_in[1:0] != 2'b00));
        fault      = illegal || misaligned;
    end

    // Extract the addressed byte/half from the read word and extend it.
    always_comb begin
        rd_shifted = dm_r_data >> {lane_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  load_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b100:  load_ext = {24'h000000, rd_shifted[7:0]};
            3'b101:  load_ext = {16'h0000, rd_shifted[15:0]};
            default: load_ext = dm_r_data;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        dm_req_d     = 1'b0;
        dm_we_d      = dm_we_q;
        dm_addr_d    = dm_addr_q;
        dm_bwe_d     = dm_bwe_q;
        dm_w_data_d  = dm_w_data_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        mem_err_d    = 1'b0;
        funct3_d     = funct3_q;
        lane_d       = lane_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    dm_we_d     = mem_we_in;
                    dm_addr_d   = {addr_in[31:2], 2'b00};
                    dm_bwe_d    = bwe_new;
                    dm_w_data_d = wdata_new;
                    funct3_d    = funct3;
                    lane_d      = addr_in[1:0];
                    if (fault) begin
                        state_d   = ERR;
                        mem_err_d = 1'b1;
                    end else begin
                        state_d  = REQ;
                        dm_req_d = 1'b1;
                    end
                end
            end
            REQ: begin
                cnt_d    = cnt_q + CNT_W'(1);
                dm_req_d = 1'b1;
                // Ack takes priority over an expiring timeout in the same cycle
                if (dm_ack) begin
                    state_d  = DONE;
                    dm_req_d = 1'b0;
                    if (!dm_we_q) begin
                        load_data_d  = load_ext;
                        load_valid_d = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = ERR;
                    dm_req_d  = 1'b0;
                    mem_err_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dm_req_q     <= 1'b0;
            dm_we_q      <= 1'b0;
            dm_addr_q    <= '0;
            dm_bwe_q     <= '0;
            dm_w_data_q  <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            mem_err_q    <= 1'b0;
            funct3_q     <= '0;
            lane_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dm_req_q     <= dm_req_d;
            dm_we_q      <= dm_we_d;
            dm_addr_q    <= dm_addr_d;
            dm_bwe_q     <= dm_bwe_d;
            dm_w_data_q  <= dm_w_data_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            mem_err_q    <= mem_err_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
        end
    end

    assign dm_req     = dm_req_q;
    assign dm_we      = dm_we_q;
    assign dm_addr    = dm_addr_q;
    assign dm_bwe     = dm_bwe_q;
    assign dm_w_data  = dm_w_data_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed table of transactions, hand-written
// reset/mul_stall/late-ack sequences, and randomized transactions checked
// against an arithmetic reference model.
module tb_mem_access_ctrl;

    localparam int unsigned TO = 16;

    logic        clk;
    logic        rst;
    logic        mem_re_in;
    logic        mem_we_in;
    logic        mul_stall;
    logic [2:0]  funct3;
    logic [31:0] addr_in;
    logic [31:0] rs2_data_in;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_bwe;
    logic [31:0] dm_w_data;
    logic        dm_ack;
    logic [31:0] dm_r_data;
    logic [31:0] load_data;
    logic        load_valid;
    logic        mem_err;
    logic        MEM_stall;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_re_in   (mem_re_in),
        .mem_we_in   (mem_we_in),
        .mul_stall   (mul_stall),
        .funct3      (funct3),
        .addr_in     (addr_in),
        .rs2_data_in (rs2_data_in),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_bwe      (dm_bwe),
        .dm_w_data   (dm_w_data),
        .dm_ack      (dm_ack),
        .dm_r_data   (dm_r_data),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .mem_err     (mem_err),
        .MEM_stall   (MEM_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          ack_at;   // REQ cycle (1-based) in which dm_ack is driven; 0 = never
        logic [31:0] e_addr;
        logic [3:0]  e_bwe;
        logic [31:0] e_wdata;
        logic        e_we;
        int          e_stall;
        int          e_req;
        int          e_lv;
        int          e_err;
        logic [31:0] e_ld;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_ld  = 32'h0;
    vec_t        tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: expected behaviour from access size, alignment and ack timing.
    function automatic void model(inout vec_t v);
        int          k;
        int          size;
        bit          legal;
        bit          sgn;
        bit          st;
        logic [31:0] sh;
        logic [31:0] mask;
        k     = int'(v.addr[1:0]);
        st    = v.we;
        legal = 1'b1;
        sgn   = 1'b0;
        size  = 4;
        if (st) begin
            case (v.f3)
                3'd0:    size = 1;
                3'd1:    size = 2;
                3'd2:    size = 4;
                default: legal = 1'b0;
            endcase
        end else begin
            case (v.f3)
                3'd0:    begin size = 1; sgn = 1'b1; end
                3'd1:    begin size = 2; sgn = 1'b1; end
                3'd2:    size = 4;
                3'd4:    size = 1;
                3'd5:    size = 2;
                default: legal = 1'b0;
            endcase
        end
        v.e_addr  = v.addr & 32'hFFFF_FFFC;
        v.e_we    = st;
        v.e_bwe   = st ? 4'(((1 << size) - 1) << k) : 4'b0000;
        v.e_wdata = v.rs2 << (8 * k);
        sh        = v.rdata >> (8 * k);
        if (size == 4) begin
            v.e_ld = v.rdata;
        end else begin
            mask   = (size == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
            v.e_ld = sh & mask;
            if (sgn && ((v.e_ld & ((mask >> 1) + 32'd1)) != 32'd0)) v.e_ld = v.e_ld | ~mask;
        end
        if (!legal || (k % size) != 0) begin
            v.e_stall = 1; v.e_req = 0; v.e_lv = 0; v.e_err = 1;
        end else if (v.ack_at >= 1 && v.ack_at <= int'(TO)) begin
            v.e_stall = 1 + v.ack_at; v.e_req = v.ack_at; v.e_lv = st ? 0 : 1; v.e_err = 0;
        end else begin
            v.e_stall = 1 + int'(TO); v.e_req = int'(TO); v.e_lv = 0; v.e_err = 1;
        end
    endfunction

    // Drive one access, hold it until the stage releases, then observe two idle cycles.
    task automatic apply(input vec_t v, input string name);
        int          stall;
        int          req;
        int          lv;
        int          err;
        bit          bus_ok;
        bit          ld_ok;
        bit          done;
        logic [31:0] hold;
        stall = 0; req = 0; lv = 0; err = 0;
        bus_ok = 1'b1; ld_ok = 1'b1; done = 1'b0;
        @(negedge clk);
        mem_re_in = v.re; mem_we_in = v.we; funct3 = v.f3; addr_in = v.addr;
        rs2_data_in = v.rs2; dm_r_data = v.rdata; mul_stall = 1'b0; dm_ack = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (MEM_stall) stall++;
            if (dm_req) begin
                req++;
                if (dm_addr !== v.e_addr || dm_bwe !== v.e_bwe || dm_we !== v.e_we ||
                    (v.e_we && dm_w_data !== v.e_wdata)) bus_ok = 1'b0;
            end
            if (load_valid) begin
                lv++;
                if (load_data !== v.e_ld) ld_ok = 1'b0;
            end
            if (mem_err) err++;
            dm_ack = dm_req && (req == v.ack_at);
            if (c > 0 && !MEM_stall) begin
                mem_re_in = 1'b0; mem_we_in = 1'b0; done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s hang: stage never released within 64 cycles", name);
        end
        for (int t = 0; t < 2; t++) begin
            #1;
            if (MEM_stall) stall++;
            if (dm_req) req++;
            if (load_valid) lv++;
            if (mem_err) err++;
            dm_ack = 1'b0;
            @(negedge clk);
        end
        chk({name, " stall_cycles"}, 32'(stall), 32'(v.e_stall));
        chk({name, " req_cycles"},   32'(req),   32'(v.e_req));
        chk({name, " load_valid_n"}, 32'(lv),    32'(v.e_lv));
        chk({name, " mem_err_n"},    32'(err),   32'(v.e_err));
        if (v.e_req > 0) chk({name, " bus_fields"}, 32'(bus_ok), 32'd1);
        if (v.e_lv > 0)  chk({name, " load_data"},  32'(ld_ok),  32'd1);
        hold = (v.e_lv > 0) ? v.e_ld : last_ld;
        chk({name, " load_hold"}, load_data, hold);
        last_ld = hold;
    endtask

    // Present an access while mul_stall is high; nothing may be issued or stalled.
    task automatic hold_mul(input vec_t v, input int n);
        @(negedge clk);
        mem_re_in = v.re; mem_we_in = v.we; funct3 = v.f3; addr_in = v.addr;
        rs2_data_in = v.rs2; dm_r_data = v.rdata; mul_stall = 1'b1; dm_ack = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("mul_stall_block", 32'({dm_req, MEM_stall}), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        vec_t v;
        int   r;
        int   ms;

        //          re    we    f3    addr          rs2           rdata         ack  e_addr        bwe      e_wdata       we   st  rq lv er e_ld
        tbl[0]  = '{1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0,        3,  32'h0000_1000, 4'b1000, 32'hA500_0000, 1'b1, 4,  3, 0, 0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 3'd0, 32'h0000_2002, 32'h0,        32'h80FF_7F01, 2,  32'h0000_2000, 4'b0000, 32'h0,        1'b0, 3,  2, 1, 0, 32'hFFFF_FFFF};
        tbl[2]  = '{1'b1, 1'b0, 3'd5, 32'h0000_2002, 32'h0,        32'h80FF_7F01, 1,  32'h0000_2000, 4'b0000, 32'h0,        1'b0, 2,  1, 1, 0, 32'h0000_80FF};
        tbl[3]  = '{1'b1, 1'b0, 3'd1, 32'h0000_2000, 32'h0,        32'h80FF_7F01, 4,  32'h0000_2000, 4'b0000, 32'h0,        1'b0, 5,  4, 1, 0, 32'h0000_7F01};
        tbl[4]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0020, 32'h0,        32'hDEAD_BEEF, 1,  32'h0000_0020, 4'b0000, 32'h0,        1'b0, 2,  1, 1, 0, 32'hDEAD_BEEF};
        tbl[5]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0101, 32'h0000_1234, 32'h0,        1,  32'h0000_0100, 4'b0000, 32'h0,        1'b1, 1,  0, 0, 1, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 3'd2, 32'h0000_0044, 32'h1234_5678, 32'h0,        2,  32'h0000_0044, 4'b1111, 32'h1234_5678, 1'b1, 3,  2, 0, 0, 32'h0};
        tbl[7]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0302, 32'h0000_BEEF, 32'h0,        1,  32'h0000_0300, 4'b1100, 32'hBEEF_0000, 1'b1, 2,  1, 0, 0, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 3'd3, 32'h0000_0000, 32'h0,        32'h0,        1,  32'h0,        4'b0000, 32'h0,        1'b0, 1,  0, 0, 1, 32'h0};
        tbl[9]  = '{1'b1, 1'b1, 3'd0, 32'h0000_0055, 32'h0000_0077, 32'h0,        1,  32'h0000_0054, 4'b0010, 32'h0000_7700, 1'b1, 2,  1, 0, 0, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 3'd4, 32'h0000_2003, 32'h0,        32'h80FF_7F01, 16, 32'h0000_2000, 4'b0000, 32'h0,        1'b0, 17, 16, 1, 0, 32'h0000_0080};
        tbl[11] = '{1'b1, 1'b0, 3'd2, 32'h0000_0080, 32'h0,        32'h0,        0,  32'h0000_0080, 4'b0000, 32'h0,        1'b0, 17, 16, 0, 1, 32'h0};

        rst = 1'b1; mem_re_in = 1'b0; mem_we_in = 1'b0; mul_stall = 1'b0; funct3 = 3'd0;
        addr_in = 32'h0; rs2_data_in = 32'h0; dm_ack = 1'b0; dm_r_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset dm_req",     32'(dm_req),     32'd0);
        chk("reset dm_we",      32'(dm_we),      32'd0);
        chk("reset dm_addr",    dm_addr,         32'd0);
        chk("reset dm_bwe",     32'(dm_bwe),     32'd0);
        chk("reset dm_w_data",  dm_w_data,       32'd0);
        chk("reset load_data",  load_data,       32'd0);
        chk("reset load_valid", 32'(load_valid), 32'd0);
        chk("reset mem_err",    32'(mem_err),    32'd0);
        chk("reset MEM_stall",  32'(MEM_stall),  32'd0);
        last_ld = 32'h0;

        for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Late ack after the timeout abort must be ignored.
        @(negedge clk);
        dm_ack = 1'b1; dm_r_data = 32'hCAFE_F00D;
        #1;
        @(negedge clk);
        dm_ack = 1'b0;
        #1;
        chk("late_ack load_valid", 32'(load_valid), 32'd0);
        chk("late_ack mem_err",    32'(mem_err),    32'd0);
        chk("late_ack dm_req",     32'(dm_req),     32'd0);
        chk("late_ack load_data",  load_data,       last_ld);

        // Reset in the second REQ cycle with an ack pending.
        @(negedge clk);
        mem_re_in = 1'b1; mem_we_in = 1'b0; funct3 = 3'd2; addr_in = 32'h0000_0040;
        dm_r_data = 32'h1357_9BDF; dm_ack = 1'b0;
        #1;
        @(negedge clk);
        #1;
        chk("rst_mid req_cycle1", 32'(dm_req), 32'd1);
        @(negedge clk);
        rst = 1'b1; dm_ack = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0; dm_ack = 1'b0; mem_re_in = 1'b0;
        #1;
        chk("rst_mid dm_req",     32'(dm_req),     32'd0);
        chk("rst_mid idle",       32'(MEM_stall),  32'd0);
        chk("rst_mid load_valid", 32'(load_valid), 32'd0);
        chk("rst_mid dm_addr",    dm_addr,         32'd0);
        chk("rst_mid load_data",  load_data,       32'd0);
        @(negedge clk);
        #1;
        chk("rst_mid no_late_valid", 32'({load_valid, mem_err, dm_req}), 32'd0);
        last_ld = 32'h0;

        // Access held behind mul_stall for three cycles, then released.
        v = tbl[4];
        hold_mul(v, 3);
        apply(v, "mul_release");

        for (int n = 0; n < 60; n++) begin
            r       = int'($urandom_range(1, 3));
            v.re    = r[0];
            v.we    = r[1];
            v.f3    = 3'($urandom_range(0, 7));
            v.addr  = $urandom;
            v.rs2   = $urandom;
            v.rdata = $urandom;
            if ($urandom_range(0, 3) == 0) v.ack_at = int'($urandom_range(0, TO + 2));
            else                           v.ack_at = int'($urandom_range(1, 4));
            model(v);
            ms = int'($urandom_range(0, 2));
            if (ms > 0) hold_mul(v, ms);
            apply(v, $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
